piso_serializer: RTL and testbench

//  Parametrised parallel-in/serial-out engine for the host serial link. Accepts one

---
 rtl/piso_serializer.sv | 173 +++++++++++++++++
 tb/tb_piso_serializer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// ---------------------------------------------------------------------------
// piso_serializer
//   Parallel-in / serial-out engine for the host serial link. One DATA_WIDTH
//   word is accepted per valid/ready handshake and shifted out as 1-bit
//   (single) or 4-bit (quad) beats, MSB- or LSB-first, one beat per cycle in
//   which tick_i is high. All outputs are registered.
//
// Ports
//   clk_i        in   system clock, rising edge
//   reset_n_i    in   asynchronous active-low reset
//   pdata_i      in   parallel word, sampled on accept
//   valid_i      in   upstream word valid
//   ready_o      out  block can accept a word
//   mode_i       in   0 = single (1 bit/beat), 1 = quad (4 bits/beat)
//   msb_first_i  in   1 = MSB first, 0 = LSB first
//   tick_i       in   beat enable while shifting
//   abort_i      in   synchronous abort of the word in flight
//   sdata_o      out  serial beat; single mode drives [0] only
//   sdata_vld_o  out  1-cycle strobe, sdata_o updated this cycle
//   busy_o       out  high while shifting
//   done_o       out  1-cycle pulse with the last beat strobe
// ---------------------------------------------------------------------------
module piso_serializer #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic [DATA_WIDTH-1:0] pdata_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic                  mode_i,
    input  logic                  msb_first_i,
    input  logic                  tick_i,
    input  logic                  abort_i,
    output logic [3:0]            sdata_o,
    output logic                  sdata_vld_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int CNT_WIDTH = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_WIDTH-1:0] QUAD_BEATS   = CNT_WIDTH'(DATA_WIDTH / 4);
    localparam logic [CNT_WIDTH-1:0] SINGLE_BEATS = CNT_WIDTH'(DATA_WIDTH);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE      = CNT_WIDTH'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    state_e                state_q;
    logic [DATA_WIDTH-1:0] word_q;
    logic [DATA_WIDTH-1:0] word_d;
    logic                  mode_q;
    logic                  msb_first_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic                  ready_q;
    logic [3:0]            sdata_q;
    logic [3:0]            beat_d;
    logic                  vld_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  last_beat_s;

    assign last_beat_s = (cnt_q == CNT_ONE);

    // Current beat and the shadow word after it has been consumed. The
    // shadow register is shifted toward the emitting end so the next beat is
    // always at a fixed bit position; no beat index is needed.
    always_comb begin
        beat_d = 4'h0;
        word_d = word_q;
        case ({mode_q, msb_first_q})
            2'b11: begin
                beat_d = word_q[DATA_WIDTH-1 -: 4];
                word_d = word_q << 3'd4;
            end
            2'b10: begin
                beat_d = word_q[3:0];
                word_d = word_q >> 3'd4;
            end
            2'b01: begin
                beat_d = {3'b000, word_q[DATA_WIDTH-1]};
                word_d = word_q << 1'b1;
            end
            2'b00: begin
                beat_d = {3'b000, word_q[0]};
                word_d = word_q >> 1'b1;
            end
            default: begin
                beat_d = 4'h0;
                word_d = word_q;
            end
        endcase
    end

    // Control FSM, shadow registers and all registered outputs.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= ST_IDLE;
            word_q      <= '0;
            mode_q      <= 1'b0;
            msb_first_q <= 1'b0;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            sdata_q     <= 4'h0;
            vld_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    vld_q  <= 1'b0;
                    done_q <= 1'b0;
                    if (valid_i && ready_q) begin
                        word_q      <= pdata_i;
                        mode_q      <= mode_i;
                        msb_first_q <= msb_first_i;
                        cnt_q       <= mode_i ? QUAD_BEATS : SINGLE_BEATS;
                        ready_q     <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= ST_SHIFT;
                    end else begin
                        // First edge after reset release raises ready here.
                        ready_q <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    done_q <= 1'b0;
                    if (abort_i) begin
                        // Abort beats a simultaneous tick, even on the last beat.
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        sdata_q <= 4'h0;
                        vld_q   <= 1'b0;
                        cnt_q   <= '0;
                    end else if (tick_i) begin
                        sdata_q <= beat_d;
                        vld_q   <= 1'b1;
                        word_q  <= word_d;
                        cnt_q   <= cnt_q - CNT_ONE;
                        if (last_beat_s) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            ready_q <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            done_q  <= 1'b0;
                        end
                    end else begin
                        // No tick: sdata_q holds the previous beat.
                        vld_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    vld_q   <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o     = ready_q;
    assign sdata_o     = sdata_q;
    assign sdata_vld_o = vld_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
module tb_piso_serializer;

    logic        clk;
    logic        reset_n;
    logic [63:0] pdata_i;
    logic        valid_i;
    logic        mode_i;
    logic        msb_first_i;
    logic        tick_i;
    logic        abort_i;
    logic        sel24;

    logic        ready64, vld64, busy64, done64;
    logic [3:0]  sdata64;
    logic        ready24, vld24, busy24, done24;
    logic [3:0]  sdata24;

    logic        ready_s, vld_s, busy_s, done_s;
    logic [3:0]  sdata_s;

    int n_cmp = 0;
    int n_err = 0;

    piso_serializer #(.DATA_WIDTH(64)) dut64 (
        .clk_i(clk), .reset_n_i(reset_n), .pdata_i(pdata_i),
        .valid_i(valid_i & ~sel24), .ready_o(ready64),
        .mode_i(mode_i), .msb_first_i(msb_first_i), .tick_i(tick_i),
        .abort_i(abort_i), .sdata_o(sdata64), .sdata_vld_o(vld64),
        .busy_o(busy64), .done_o(done64)
    );

    piso_serializer #(.DATA_WIDTH(24)) dut24 (
        .clk_i(clk), .reset_n_i(reset_n), .pdata_i(pdata_i[23:0]),
        .valid_i(valid_i & sel24), .ready_o(ready24),
        .mode_i(mode_i), .msb_first_i(msb_first_i), .tick_i(tick_i),
        .abort_i(abort_i), .sdata_o(sdata24), .sdata_vld_o(vld24),
        .busy_o(busy24), .done_o(done24)
    );

    assign ready_s = sel24 ? ready24 : ready64;
    assign vld_s   = sel24 ? vld24   : vld64;
    assign busy_s  = sel24 ? busy24  : busy64;
    assign done_s  = sel24 ? done24  : done64;
    assign sdata_s = sel24 ? sdata24 : sdata64;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Beat k of a word, straight from the bit-ordering rules.
    function automatic logic [3:0] ref_beat(input logic [63:0] w, input int dw,
                                            input bit m, input bit msb, input int k);
        logic [63:0] t;
        if (m) t = msb ? (w >> (dw - 4 - 4 * k)) : (w >> (4 * k));
        else   t = msb ? (w >> (dw - 1 - k))     : (w >> k);
        return m ? t[3:0] : {3'b000, t[0]};
    endfunction

    // Send one word and follow it to completion or abort, checking each cycle.
    // per=0 means random tick; abt<0 means no abort.
    task automatic run_word(input logic [63:0] w, input bit m, input bit msb, input bit s24,
                            input int per, input int abt,
                            output int nstb, output logic [3:0] first_b, output logic [3:0] last_b);
        int dw, n, cyc, guard;
        logic [3:0] prev;
        bit fin, tk, ab, aborted;
        dw = s24 ? 24 : 64;
        n = m ? dw / 4 : dw;
        sel24 = s24;
        guard = 0;
        while (!ready_s && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("ready_wait", ready_s, 1'b1);
        pdata_i = w; mode_i = m; msb_first_i = msb; valid_i = 1'b1;
        tick_i = 1'b1; abort_i = 1'b1;   // ignored while idle
        @(negedge clk);
        valid_i = 1'b0; abort_i = 1'b0;
        pdata_i = {$urandom, $urandom}; mode_i = ~m; msb_first_i = ~msb;
        check("busy_after_accept", busy_s, 1'b1);
        check("ready_after_accept", ready_s, 1'b0);
        prev = sdata_s; nstb = 0; cyc = 0; fin = 0; aborted = 0; first_b = 4'h0; last_b = 4'h0;
        while (!fin && cyc < 1000) begin
            tk = (per == 0) ? bit'($urandom_range(0, 1)) : ((cyc % per) == 0);
            ab = (abt >= 0) && (nstb == abt);
            tick_i = tk; abort_i = ab;
            @(negedge clk);
            cyc++;
            if (ab) begin
                check("abort_ready", ready_s, 1'b1);
                check("abort_busy", busy_s, 1'b0);
                check("abort_sdata", sdata_s, 4'h0);
                check("abort_vld", vld_s, 1'b0);
                check("abort_done", done_s, 1'b0);
                fin = 1; aborted = 1;
            end else begin
                check("strobe_vs_tick", vld_s, tk);
                if (vld_s) begin
                    check("beat", sdata_s, ref_beat(w, dw, m, msb, nstb));
                    if (nstb == 0) first_b = sdata_s;
                    last_b = sdata_s;
                    nstb++;
                    check("done_with_last", done_s, nstb == n);
                    if (nstb == n) begin
                        fin = 1;
                        check("busy_at_done", busy_s, 1'b0);
                        if (per > 0) check("done_latency", cyc, (n - 1) * per + 1);
                    end
                end else begin
                    check("sdata_hold", sdata_s, prev);
                    check("done_idle", done_s, 1'b0);
                end
            end
            prev = sdata_s;
        end
        if (!fin) check("word_timeout", 1'b0, 1'b1);
        tick_i = 1'b0; abort_i = 1'b0;
        @(negedge clk);
        check("ready_next", ready_s, 1'b1);
        check("vld_next", vld_s, 1'b0);
        check("done_next", done_s, 1'b0);
        if (!aborted) check("sdata_keep_last", sdata_s, last_b);
    endtask

    typedef struct {
        logic [63:0] w;
        bit          m;
        bit          msb;
        bit          s24;
        int          per;
        int          abt;
        int          exp_n;
        logic [3:0]  exp_first;
        logic [3:0]  exp_last;
    } row_t;

    row_t tbl[10];

    initial begin
        int nstb, dw, n, abt, per;
        logic [3:0] fb, lb;
        logic [63:0] w;
        bit m, msb, s24;

        tbl[0] = '{64'h0123456789ABCDEF, 1'b1, 1'b1, 1'b0, 1, -1, 16, 4'h0, 4'hF};
        tbl[1] = '{64'h0123456789ABCDEF, 1'b1, 1'b0, 1'b0, 1, -1, 16, 4'hF, 4'h0};
        tbl[2] = '{64'h8000000000000001, 1'b0, 1'b1, 1'b0, 1, -1, 64, 4'h1, 4'h1};
        tbl[3] = '{64'h8000000000000002, 1'b0, 1'b0, 1'b0, 1, -1, 64, 4'h0, 4'h1};
        tbl[4] = '{64'h0123456789ABCDEF, 1'b1, 1'b1, 1'b0, 3, -1, 16, 4'h0, 4'hF};
        tbl[5] = '{64'h0123456789ABCDEF, 1'b1, 1'b1, 1'b0, 1,  5,  5, 4'h0, 4'h4};
        tbl[6] = '{64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b1, 1'b0, 1, -1, 16, 4'hF, 4'hF};
        tbl[7] = '{64'hFEDCBA9876543210, 1'b1, 1'b0, 1'b0, 1, 15, 15, 4'h0, 4'hE};
        tbl[8] = '{64'h0000000000A5A5A5, 1'b0, 1'b0, 1'b1, 1, -1, 24, 4'h1, 4'h1};
        tbl[9] = '{64'h0000000000A5A5A5, 1'b1, 1'b1, 1'b1, 1, -1,  6, 4'hA, 4'h5};

        reset_n = 1'b0; pdata_i = '0; valid_i = 1'b0; mode_i = 1'b0;
        msb_first_i = 1'b0; tick_i = 1'b0; abort_i = 1'b0; sel24 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready64", ready64, 1'b0);
        check("rst_ready24", ready24, 1'b0);
        check("rst_sdata", sdata64, 4'h0);
        check("rst_vld", vld64, 1'b0);
        check("rst_busy", busy64, 1'b0);
        check("rst_done", done64, 1'b0);
        reset_n = 1'b1;
        #1 check("ready_before_edge", ready64, 1'b0);
        @(negedge clk);
        check("ready_first_edge64", ready64, 1'b1);
        check("ready_first_edge24", ready24, 1'b1);

        for (int i = 0; i < 10; i++) begin
            run_word(tbl[i].w, tbl[i].m, tbl[i].msb, tbl[i].s24, tbl[i].per, tbl[i].abt, nstb, fb, lb);
            check($sformatf("row%0d_strobes", i), nstb, tbl[i].exp_n);
            check($sformatf("row%0d_first", i), fb, tbl[i].exp_first);
            check($sformatf("row%0d_last", i), lb, tbl[i].exp_last);
        end

        // Reset in the middle of a word.
        sel24 = 1'b0;
        pdata_i = 64'h0123456789ABCDEF; mode_i = 1'b1; msb_first_i = 1'b1; valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0; tick_i = 1'b1; nstb = 0;
        for (int c = 0; c < 40 && nstb < 7; c++) begin
            @(negedge clk);
            if (vld64) nstb++;
        end
        check("mid_rst_reached_beat7", nstb, 7);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_sdata", sdata64, 4'h0);
        check("mid_rst_vld", vld64, 1'b0);
        check("mid_rst_busy", busy64, 1'b0);
        check("mid_rst_ready", ready64, 1'b0);
        @(negedge clk);
        check("mid_rst_ready_held", ready64, 1'b0);
        tick_i = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        check("mid_rst_ready_up", ready64, 1'b1);
        check("mid_rst_busy_after", busy64, 1'b0);
        check("mid_rst_done_after", done64, 1'b0);
        run_word(64'h0000000000A5A5A5, 1'b0, 1'b0, 1'b1, 1, -1, nstb, fb, lb);
        check("post_rst24_strobes", nstb, 24);

        // Randomized words against the reference model.
        for (int r = 0; r < 30; r++) begin
            w = {$urandom, $urandom};
            m = bit'($urandom_range(0, 1));
            msb = bit'($urandom_range(0, 1));
            s24 = bit'($urandom_range(0, 3) == 0);
            per = $urandom_range(0, 3);
            dw = s24 ? 24 : 64;
            n = m ? dw / 4 : dw;
            abt = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, n - 1)) : -1;
            run_word(w, m, msb, s24, per, abt, nstb, fb, lb);
            check("rand_strobes", nstb, (abt >= 0) ? abt : n);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
